node_rom_arbiter: RTL and testbench
===================================

Name: node_rom_arbiter

Overview:
- Round-robin arbiter that shares one synchronous-read octree node ROM port among NUM_CORES ray processor cores.
- Sits between the RayProcessor address/node ports and the octant ROM; replaces the per-core dedicated ROM ports and the shared read-enable wiring.
- Tags each granted read, then returns the ROM word only to the core that issued the request, in issue order.

Parameters:
NUM_CORES, 4, number of requesting cores, 1..8
ADDR_W, 32, node address width
DATA_W, 32, node word width
MEM_LAT, 1, ROM read latency in cycles from mem_ren sampled to mem_dout valid, 1..4

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
en  in  1  grant enable; low blocks new grants, in-flight reads still complete
req_valid  in  NUM_CORES  per-core read request
req_addr  in  NUM_CORES*ADDR_W  per-core node address; core i occupies bits [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_CORES  one-hot-or-zero grant; handshake when req_valid[i] & req_ready[i]
rsp_valid  out  NUM_CORES  one-hot-or-zero response strobe
rsp_data  out  DATA_W  ROM word, broadcast to all cores; qualified by rsp_valid
mem_ren  out  1  ROM read enable
mem_addr  out  ADDR_W  ROM address
mem_dout  in  DATA_W  ROM read data
busy  out  1  high while any request is pending or any read is in flight

Behaviour:
- Reset (async assert, sync deassert internally): mem_ren=0, mem_addr=0, rsp_valid=0, req_ready=0, tag pipeline cleared, rr_ptr=NUM_CORES-1 so core 0 has first priority.
- Arbitration is combinational each cycle.
  - Search starts at (rr_ptr+1) mod NUM_CORES and wraps; the first core with req_valid high wins.
  - req_ready[winner]=1 only when en=1; all other req_ready bits are 0.
  - req_ready never depends on rsp path state: issue is possible every cycle.
- On a handshake in cycle c:
  - rr_ptr <= winner.
  - mem_ren=1 and mem_addr=req_addr[winner] are registered and appear during cycle c+1.
  - Tag {valid, winner} enters a MEM_LAT+1 deep shift pipeline.
- Cycle with no handshake: mem_ren=0, mem_addr holds its last value, rr_ptr holds.
- Response:
  - During cycle c+1+MEM_LAT, rsp_valid[winner]=1 (registered from the tag pipe).
  - rsp_data = mem_dout (combinational passthrough). Data is only defined while some rsp_valid bit is high.
- Ordering: responses are strictly in grant order.
  - Throughput is one read per cycle.
  - A core may have multiple reads in flight; matching responses to its requests in order is the core's responsibility.
- Requests are not required to be held:
  - A core may drop req_valid before it is granted; nothing is issued for it.
  - req_addr is sampled only in the handshake cycle.
- en low: no new grants and rr_ptr is frozen. Tags already in the pipe still produce their rsp_valid on schedule.
- busy = (|req_valid) | any tag valid in the pipe | mem_ren.
- NUM_CORES=1: the arbiter degenerates to req_ready=en, with latency identical to the general case.
- Reset mid-operation: every in-flight tag is discarded, and no rsp_valid is produced after reset asserts. The ROM is not told to abort; its stale data is ignored.
- Only the first MEM_LAT+1 tag pipe stages are used. Index widths use $clog2(NUM_CORES) with a minimum of 1.

Test Plan:
1. NUM_CORES=4, MEM_LAT=1, only core 0 requests addr 0x10 in cycle 0 after reset -> req_ready=4'b0001 in cycle 0; mem_ren=1, mem_addr=0x10 in cycle 1; rsp_valid=4'b0001 with rsp_data=ROM[0x10] in cycle 2; busy low from cycle 3.
2. All 4 cores request every cycle with distinct addresses -> grants 0,1,2,3,0,1,… one per cycle; mem_ren continuously high from cycle 1; rsp_valid rotates 0001,0010,0100,1000 starting cycle 2, each with the correct ROM word.
3. Core 1 granted once (rr_ptr=1), then cores 1 and 3 request together -> core 3 granted first, core 1 the next cycle; responses arrive in the order 3, 1.
4. Core 2 requesting continuously, en=0 for cycles 5–9 while a read issued in cycle 4 is in flight -> req_ready=0 in cycles 5–9; rsp_valid[2] still pulses in cycle 6; grant resumes in cycle 10.
5. Three reads in flight, reset_n driven low for 1 cycle -> all outputs 0 immediately; no rsp_valid in any later cycle until new requests; the next grant goes to the lowest-index requesting core.
6. MEM_LAT=3, core 1 requests addr 0x7 in cycle 0 -> mem_ren in cycle 1, rsp_valid[1] in cycle 4 with ROM[0x7]; back-to-back requests give back-to-back responses with no bubbles.

Source files
------------

// File: rtl/node_rom_arbiter_if.sv
// Bundle between the ray processor cores, the node ROM port and the arbiter
// that shares it. The arbiter takes the slave view; the cores and ROM take
// the master view.
interface node_rom_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  // Core side: per-core request/grant and broadcast response
  logic [NUM_CORES-1:0]        req_valid;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES-1:0]        req_ready;
  logic [NUM_CORES-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_data;

  // ROM side: single synchronous-read port
  logic                        mem_ren;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_dout;

  modport slave (
    input  req_valid, req_addr, mem_dout,
    output req_ready, rsp_valid, rsp_data, mem_ren, mem_addr
  );

  modport master (
    output req_valid, req_addr, mem_dout,
    input  req_ready, rsp_valid, rsp_data, mem_ren, mem_addr
  );
endinterface

// File: rtl/node_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read octree node ROM among
// NUM_CORES ray processor cores. Each grant issues one registered ROM read
// and pushes a tag {valid, core} down a MEM_LAT+1 deep pipe; the tag leaving
// the pipe steers the ROM word to the core that asked for it, in issue order.
module node_rom_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  output logic              busy,
  node_rom_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] core;
  } tag_t;

  logic [1:0]           rst_sync;
  logic                 rst_n_int;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic                 grant;
  logic                 mem_ren;
  logic [ADDR_W-1:0]    mem_addr;
  logic [NUM_CORES-1:0] req_ready;
  logic [NUM_CORES-1:0] rsp_valid;
  logic                 tag_any;
  tag_t                 tag_pipe [MEM_LAT+1];

  // Reset synchronizer: assertion reaches every flop at once, release is
  // aligned to clk so no flop leaves reset on a different edge than another.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    // NOTE: defaults first so every path assigns found/winner; no latch.
    found  = 1'b0;
    winner = '0;
    for (int off = 1; off <= NUM_CORES; off++) begin
      // NOTE: blocking assignment here so found stops later cores winning
      // within this same evaluation.
      if (!found && bus.req_valid[(int'(rr_ptr) + off) % NUM_CORES]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(rr_ptr) + off) % NUM_CORES);
      end
    end
  end

  // A grant needs en and a finished reset; it never waits on the response side.
  assign grant = en && found && rst_n_int;

  // One-hot grant to the winner, zero when nothing is issued.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Issue stage: register the ROM read and advance the priority pointer.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rr_ptr   <= IDX_W'(NUM_CORES - 1);
      mem_ren  <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_ren <= grant;
      if (grant) begin
        rr_ptr   <= winner;
        mem_addr <= bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
      end
    end
  end

  // Tag pipe: stage k is visible k+1 cycles after the grant, so the last
  // stage lines up with the ROM word MEM_LAT cycles after mem_ren.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      // NOTE: the tag array is reset because an in-flight tag surviving a
      // reset would fire a stale rsp_valid; unlike a RAM it must be cleared.
      for (int k = 0; k <= MEM_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: grant, core: winner};
      for (int k = 1; k <= MEM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Response strobe decoded from the registered last tag stage.
  always_comb begin
    rsp_valid = '0;
    if (tag_pipe[MEM_LAT].valid) rsp_valid[tag_pipe[MEM_LAT].core] = 1'b1;
  end

  // Any tag still travelling keeps the arbiter busy.
  always_comb begin
    tag_any = 1'b0;
    for (int k = 0; k <= MEM_LAT; k++) tag_any = tag_any | tag_pipe[k].valid;
  end

  assign busy          = (|bus.req_valid) | tag_any | mem_ren;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = bus.mem_dout;
  assign bus.mem_ren   = mem_ren;
  assign bus.mem_addr  = mem_addr;

endmodule

// File: tb/tb_node_rom_arbiter.sv
// Directed bench for node_rom_arbiter: a 4-core MEM_LAT=1 instance and a
// 4-core MEM_LAT=3 instance, each behind a behavioural synchronous ROM.
module tb_node_rom_arbiter;

  logic clk;
  logic reset_n;
  logic en_a, en_b;
  logic busy_a, busy_b;
  int   vectors;
  int   miscompares;

  node_rom_arbiter_if #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32)) a_if ();
  node_rom_arbiter_if #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32)) b_if ();

  node_rom_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en_a), .busy(busy_a), .bus(a_if)
  );

  node_rom_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en_b), .busy(busy_b), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a fixed scramble of the address
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Synchronous ROMs: latency 1 and latency 3 from the sampled address
  logic [31:0] rom_a;
  logic [31:0] rom_b [3];
  always @(posedge clk) begin
    rom_a    <= rom(a_if.mem_addr);
    rom_b[0] <= rom(b_if.mem_addr);
    rom_b[1] <= rom_b[0];
    rom_b[2] <= rom_b[1];
  end
  assign a_if.mem_dout = rom_a;
  assign b_if.mem_dout = rom_b[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; the new cycle starts here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr_a(input int core, input logic [31:0] a);
    a_if.req_addr[core*32 +: 32] = a;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  // Hard stop if the sequence ever overruns.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset_n         = 1'b0;
    en_a            = 1'b1;
    en_b            = 1'b1;
    a_if.req_valid  = '0;
    a_if.req_addr   = '0;
    b_if.req_valid  = '0;
    b_if.req_addr   = '0;

    // Reset state
    #2;
    check("rst a.mem_ren",   a_if.mem_ren,   0);
    check("rst a.mem_addr",  a_if.mem_addr,  0);
    check("rst a.rsp_valid", a_if.rsp_valid, 0);
    check("rst a.req_ready", a_if.req_ready, 0);
    check("rst a.busy",      busy_a,         0);
    check("rst b.rsp_valid", b_if.rsp_valid, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // 1: single request from core 0
    a_if.req_valid = 4'b0001;
    set_addr_a(0, 32'h10);
    @(negedge clk);
    check("t1 c0 req_ready", a_if.req_ready, 4'b0001);
    check("t1 c0 mem_ren",   a_if.mem_ren,   0);
    check("t1 c0 busy",      busy_a,         1);
    tick();
    a_if.req_valid = '0;
    @(negedge clk);
    check("t1 c1 mem_ren",   a_if.mem_ren,   1);
    check("t1 c1 mem_addr",  a_if.mem_addr,  32'h10);
    check("t1 c1 rsp_valid", a_if.rsp_valid, 0);
    tick();
    @(negedge clk);
    check("t1 c2 rsp_valid", a_if.rsp_valid, 4'b0001);
    check("t1 c2 rsp_data",  a_if.rsp_data,  rom(32'h10));
    check("t1 c2 mem_ren",   a_if.mem_ren,   0);
    tick();
    @(negedge clk);
    check("t1 c3 busy",      busy_a,         0);
    check("t1 c3 rsp_valid", a_if.rsp_valid, 0);
    check("t1 c3 mem_addr",  a_if.mem_addr,  32'h10);

    // 2: all cores request every cycle
    apply_reset();
    for (int i = 0; i < 4; i++) set_addr_a(i, 32'h100 + i * 4);
    for (int k = 0; k < 10; k++) begin
      a_if.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      check($sformatf("t2 k%0d req_ready", k), a_if.req_ready,
            (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
      if (k >= 1 && k <= 8) begin
        check($sformatf("t2 k%0d mem_ren", k),  a_if.mem_ren, 1);
        check($sformatf("t2 k%0d mem_addr", k), a_if.mem_addr, 32'h100 + ((k - 1) % 4) * 4);
      end
      if (k >= 2) begin
        check($sformatf("t2 k%0d rsp_valid", k), a_if.rsp_valid, 4'b0001 << ((k - 2) % 4));
        check($sformatf("t2 k%0d rsp_data", k),  a_if.rsp_data,
              rom(32'h100 + ((k - 2) % 4) * 4));
      end else begin
        check($sformatf("t2 k%0d rsp_valid", k), a_if.rsp_valid, 0);
      end
      tick();
    end

    // 3: core 1 granted, then cores 1 and 3 together -> 3 first, then 1
    a_if.req_valid = 4'b0010;
    set_addr_a(1, 32'h20);
    @(negedge clk);
    check("t3 c0 req_ready", a_if.req_ready, 4'b0010);
    tick();
    a_if.req_valid = 4'b1010;
    set_addr_a(3, 32'h23);
    @(negedge clk);
    check("t3 c1 req_ready", a_if.req_ready, 4'b1000);
    tick();
    a_if.req_valid = 4'b0010;
    set_addr_a(1, 32'h22);
    @(negedge clk);
    check("t3 c2 req_ready", a_if.req_ready, 4'b0010);
    check("t3 c2 rsp_valid", a_if.rsp_valid, 4'b0010);
    check("t3 c2 rsp_data",  a_if.rsp_data,  rom(32'h20));
    tick();
    a_if.req_valid = '0;
    @(negedge clk);
    check("t3 c3 rsp_valid", a_if.rsp_valid, 4'b1000);
    check("t3 c3 rsp_data",  a_if.rsp_data,  rom(32'h23));
    tick();
    @(negedge clk);
    check("t3 c4 rsp_valid", a_if.rsp_valid, 4'b0010);
    check("t3 c4 rsp_data",  a_if.rsp_data,  rom(32'h22));
    tick();

    // 4: core 2 continuous, en low in cycles 5..9 with a read in flight
    apply_reset();
    a_if.req_valid = 4'b0100;
    set_addr_a(2, 32'h42);
    for (int c = 4; c <= 10; c++) begin
      en_a = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      @(negedge clk);
      check($sformatf("t4 c%0d req_ready", c), a_if.req_ready,
            (c >= 5 && c <= 9) ? 4'b0000 : 4'b0100);
      check($sformatf("t4 c%0d mem_ren", c), a_if.mem_ren, (c == 5) ? 1 : 0);
      check($sformatf("t4 c%0d rsp_valid", c), a_if.rsp_valid, (c == 6) ? 4'b0100 : 4'b0000);
      if (c == 6) check("t4 c6 rsp_data", a_if.rsp_data, rom(32'h42));
      check($sformatf("t4 c%0d busy", c), busy_a, 1);
      tick();
    end
    en_a           = 1'b1;
    a_if.req_valid = '0;
    repeat (3) tick();

    // 5: reset with reads in flight
    apply_reset();
    a_if.req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) set_addr_a(i, 32'h50 + i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5 c%0d req_ready", c), a_if.req_ready, 4'b0001 << c);
      if (c < 2) tick();
    end
    #1;
    reset_n = 1'b0;
    #1;
    check("t5 rst req_ready", a_if.req_ready, 0);
    check("t5 rst mem_ren",   a_if.mem_ren,   0);
    check("t5 rst mem_addr",  a_if.mem_addr,  0);
    check("t5 rst rsp_valid", a_if.rsp_valid, 0);
    a_if.req_valid = '0;
    #1;
    check("t5 rst busy", busy_a, 0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("t5 post%0d rsp_valid", c), a_if.rsp_valid, 0);
      tick();
    end
    a_if.req_valid = 4'b0110;
    set_addr_a(1, 32'h61);
    @(negedge clk);
    check("t5 new req_ready", a_if.req_ready, 4'b0010);
    tick();
    a_if.req_valid = '0;
    @(negedge clk);
    check("t5 new mem_addr", a_if.mem_addr, 32'h61);
    tick();
    @(negedge clk);
    check("t5 new rsp_valid", a_if.rsp_valid, 4'b0010);
    check("t5 new rsp_data",  a_if.rsp_data,  rom(32'h61));
    tick();

    // 6: MEM_LAT=3 instance, core 1 back-to-back from addr 0x7
    for (int k = 0; k < 9; k++) begin
      b_if.req_valid = (k < 4) ? 4'b0010 : 4'b0000;
      b_if.req_addr[32 +: 32] = 32'h7 + k;
      @(negedge clk);
      check($sformatf("t6 k%0d req_ready", k), b_if.req_ready, (k < 4) ? 4'b0010 : 4'b0000);
      check($sformatf("t6 k%0d mem_ren", k), b_if.mem_ren, (k >= 1 && k <= 4) ? 1 : 0);
      if (k >= 1 && k <= 4)
        check($sformatf("t6 k%0d mem_addr", k), b_if.mem_addr, 32'h7 + k - 1);
      check($sformatf("t6 k%0d rsp_valid", k), b_if.rsp_valid,
            (k >= 4 && k <= 7) ? 4'b0010 : 4'b0000);
      if (k >= 4 && k <= 7)
        check($sformatf("t6 k%0d rsp_data", k), b_if.rsp_data, rom(32'h7 + k - 4));
      tick();
    end
    @(negedge clk);
    check("t6 end busy", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
